// File: rtl/fp_sqrt_pkg.sv
// Shared types and constants for the fp32 square-root datapath.
// The sideband travels as an 11-bit vector {sign, cls, exp_res}; side_t
// gives the same bits named fields.
package fp_sqrt_pkg;

  localparam int SIDE_W      = 11;
  localparam int SIDE_SIGN   = 10;
  localparam int SIDE_CLS_LO = 8;
  localparam int SIDE_EXP_LO = 0;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  typedef struct packed {
    logic       sign;
    cls_e       cls;
    logic [7:0] exp_res;
  } side_t;

  typedef struct packed {
    logic        inv;
    logic [31:0] res;
  } pack_t;

  // Special-case priority matters: a negative NaN is still a quiet NaN
  // (no invalid flag), and -0 is a legal operand whose root is -0.
  function automatic pack_t pack_root(side_t s, logic [22:0] frac);
    pack_t p;
    p.inv = 1'b0;
    p.res = QNAN;
    if (s.cls == CLS_NAN) begin
      p.res = QNAN;
    end else if (s.sign && (s.cls != CLS_ZERO)) begin
      p.res = QNAN;
      p.inv = 1'b1;
    end else if (s.cls == CLS_ZERO) begin
      p.res = {s.sign, 31'b0};
    end else if (s.cls == CLS_INF) begin
      p.res = PINF;
    end else begin
      // Truncated root, hidden bit already dropped by the caller.
      p.res = {1'b0, s.exp_res, frac};
    end
    return p;
  endfunction

endpackage

// File: rtl/fp_fifo_sync.sv
// Synchronous FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is
// dropped and reported on ovf. The head reads as zero while empty.
module fp_fifo_sync #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, push_ok, pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf     = push & full & ~pop_ok;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy tracks accepted pushes and pops only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp32_sqrt_post.sv
// Back end of the fp32 square-root datapath: delays each operand's
// sideband to line up with the integer root core, packs the result into
// IEEE-754 single format, queues it, and issues credits upstream so the
// queue can never be overrun by well-behaved issue logic.
module fp32_sqrt_post
  import fp_sqrt_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [10:0] issue_side,
  input  logic [23:0] root,
  input  logic        root_vld,
  output logic        can_issue,
  output logic [31:0] res,
  output logic        res_inv,
  output logic        res_vld,
  input  logic        res_rdy,
  output logic        align_err,
  output logic        ovf_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  // Sideband delay line, one stage per core pipeline stage.
  logic [LATENCY-1:0]             vld_pipe;
  logic [LATENCY-1:0][SIDE_W-1:0] side_pipe;

  logic          head_vld;
  side_t         head_side;
  pack_t         pk;
  logic          push, pop;
  logic [32:0]   fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_ovf;
  logic [CW-1:0] inflight;
  logic          unused_hidden;

  // Shift the sideband every cycle; the core has en tied high so its
  // latency is fixed and the head lines up with root_vld.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      side_pipe <= '0;
    end else begin
      vld_pipe[0]  <= issue;
      side_pipe[0] <= issue_side;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        side_pipe[i] <= side_pipe[i-1];
      end
    end
  end

  assign head_vld      = vld_pipe[LATENCY-1];
  assign head_side     = side_t'(side_pipe[LATENCY-1]);
  assign unused_hidden = root[23];
  assign pk            = pack_root(head_side, root[22:0]);

  // A root without matching sideband is never written.
  assign push = root_vld & head_vld;
  assign pop  = res_vld & res_rdy;

  fp_fifo_sync #(
    .WIDTH (33),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({pk.inv, pk.res}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .ovf   (fifo_ovf)
  );

  assign res     = fifo_dout[31:0];
  assign res_inv = fifo_dout[32];
  assign res_vld = ~fifo_empty;

  // Roots still inside the core; saturating so a stray root_vld after
  // reset cannot wrap the count and starve the credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({issue, root_vld})
        2'b10:   if (inflight != CNT_MAX) inflight <= inflight + CNT_ONE;
        2'b01:   if (inflight != '0)      inflight <= inflight - CNT_ONE;
        default: inflight <= inflight;
      endcase
    end
  end

  // Every in-flight root reserves a FIFO slot, so credit is granted only
  // while reserved plus occupied slots leave room for one more.
  assign can_issue = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_C;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_err <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      if (root_vld && !head_vld) align_err <= 1'b1;
      if (fifo_ovf)              ovf_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp32_sqrt_post.sv
// Bench for fp32_sqrt_post. The bench plays the integer root core: every
// issued operand schedules its root LATENCY cycles later. Expected results
// go into a scoreboard queue that a negedge monitor checks on each pop.
module tb_fp32_sqrt_post;

  localparam int LAT = 8;
  localparam int DEP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue = 1'b0;
  logic [10:0] issue_side = '0;
  logic [23:0] root = '0;
  logic        root_vld = 1'b0;
  logic        res_rdy = 1'b0;
  logic        can_issue, res_inv, res_vld, align_err, ovf_err;
  logic [31:0] res;

  always #5 clk = ~clk;

  fp32_sqrt_post #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .issue_side (issue_side),
    .root       (root),
    .root_vld   (root_vld),
    .can_issue  (can_issue),
    .res        (res),
    .res_inv    (res_inv),
    .res_vld    (res_vld),
    .res_rdy    (res_rdy),
    .align_err  (align_err),
    .ovf_err    (ovf_err)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        sched_vld [64];
  logic [23:0] sched_root [64];
  logic [32:0] sb [$];
  logic        stall_q = 1'b0;
  logic [32:0] stall_val = '0;

  typedef struct {
    string       name;
    logic [10:0] side;
    logic [23:0] rt;
    logic [32:0] exp_out;  // {inv, res}
  } vec_t;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // IEEE sqrt result for an operand already classified upstream; the
  // core root is 1.f in Q1.23 and rounding is truncation.
  function automatic logic [32:0] model(logic sign, logic [1:0] cls, logic [7:0] e, logic [23:0] r);
    if (cls == 2'd3)           return {1'b0, 32'h7FC0_0000};
    if (sign && cls != 2'd1)   return {1'b1, 32'h7FC0_0000};
    if (cls == 2'd1)           return {1'b0, sign, 31'b0};
    if (cls == 2'd2)           return {1'b0, 32'h7F80_0000};
    return {1'b0, 1'b0, e, r[22:0]};
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 64; i++) if (sched_vld[i]) n++;
    return n;
  endfunction

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    issue    = 1'b0;
    root_vld = sched_vld[cyc % 64];
    root     = sched_root[cyc % 64];
    sched_vld[cyc % 64] = 1'b0;
  endtask

  task automatic do_issue(input logic [10:0] s, input logic [23:0] r,
                          input logic [32:0] exp_out, input bit expect_it);
    issue      = 1'b1;
    issue_side = s;
    sched_vld[(cyc + LAT) % 64]  = 1'b1;
    sched_root[(cyc + LAT) % 64] = r;
    if (expect_it) sb.push_back(exp_out);
  endtask

  task automatic rand_issue();
    logic [1:0]  c;
    logic        sg;
    logic [7:0]  e;
    logic [23:0] r;
    int pick;
    pick = $urandom_range(0, 7);
    c  = (pick < 4) ? 2'd0 : 2'(pick - 4);
    sg = ($urandom_range(0, 3) == 0);
    e  = 8'($urandom);
    r  = {1'b1, 23'($urandom)};
    do_issue({sg, c, e}, r, model(sg, c, e, r), 1'b1);
  endtask

  task automatic drain();
    int k = 0;
    res_rdy = 1'b1;
    while ((sb.size() != 0 || res_vld || pending() != 0) && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results still expected after %0d cycles", sb.size(), k);
      sb.delete();
    end
  endtask

  // Fill the FIFO under backpressure, obeying can_issue; returns issue count.
  task automatic fill(output int n_iss);
    n_iss = 0;
    res_rdy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (can_issue) begin
        rand_issue();
        n_iss++;
      end
    end
  endtask

  // Checks every popped result against the scoreboard, and that the head
  // does not change while stalled.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && res_vld) begin
      if (stall_q) chk("hold_stable", {res_inv, res}, stall_val);
      if (res_rdy) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got %h, expected no result", {res_inv, res});
        end else begin
          e = sb.pop_front();
          chk("result", {res_inv, res}, e);
        end
      end
    end
    stall_q   = !rst && res_vld && !res_rdy;
    stall_val = {res_inv, res};
  end

  initial begin
    vec_t vt [9];
    int   n_iss;
    int   c0;

    for (int i = 0; i < 64; i++) begin
      sched_vld[i]  = 1'b0;
      sched_root[i] = '0;
    end

    vt[0] = '{"sqrt4",   {1'b0, 2'd0, 8'h80}, 24'h800000, {1'b0, 32'h4000_0000}};
    vt[1] = '{"sqrt2",   {1'b0, 2'd0, 8'h7F}, 24'hB504F3, {1'b0, 32'h3FB5_04F3}};
    vt[2] = '{"neg_one", {1'b1, 2'd0, 8'h7F}, 24'h800000, {1'b1, 32'h7FC0_0000}};
    vt[3] = '{"neg_zero",{1'b1, 2'd1, 8'h00}, 24'h000000, {1'b0, 32'h8000_0000}};
    vt[4] = '{"pos_inf", {1'b0, 2'd2, 8'hFF}, 24'h000000, {1'b0, 32'h7F80_0000}};
    vt[5] = '{"nan",     {1'b0, 2'd3, 8'hFF}, 24'h000000, {1'b0, 32'h7FC0_0000}};
    vt[6] = '{"pos_zero",{1'b0, 2'd1, 8'h00}, 24'h000000, {1'b0, 32'h0000_0000}};
    vt[7] = '{"neg_nan", {1'b1, 2'd3, 8'hFF}, 24'h123456, {1'b0, 32'h7FC0_0000}};
    vt[8] = '{"neg_inf", {1'b1, 2'd2, 8'hFF}, 24'h000000, {1'b1, 32'h7FC0_0000}};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_res_vld",   33'(res_vld),   33'(0));
    chk("rst_res",       33'(res),       33'(0));
    chk("rst_res_inv",   33'(res_inv),   33'(0));
    chk("rst_can_issue", 33'(can_issue), 33'(1));
    chk("rst_align_err", 33'(align_err), 33'(0));
    chk("rst_ovf_err",   33'(ovf_err),   33'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Issue-to-valid latency: res_vld low in t0+8, high in t0+9
    res_rdy = 1'b1;
    tick();
    c0 = cyc;
    do_issue(vt[0].side, vt[0].rt, vt[0].exp_out, 1'b1);
    while (cyc < c0 + LAT) tick();
    @(negedge clk);
    chk("lat_before", 33'(res_vld), 33'(0));
    tick();
    @(negedge clk);
    chk("lat_rise", 33'(res_vld), 33'(1));
    drain();

    // Table vectors issued back to back
    for (int i = 0; i < 9; i++) begin
      tick();
      do_issue(vt[i].side, vt[i].rt, vt[i].exp_out, 1'b1);
    end
    drain();

    // Credit exhaustion under backpressure and recovery
    fill(n_iss);
    chk("credit_issues", 33'(n_iss), 33'(DEP));
    @(negedge clk);
    chk("credit_low",  33'(can_issue), 33'(0));
    chk("full_vld",    33'(res_vld),   33'(1));
    tick();
    res_rdy = 1'b1;
    @(negedge clk);
    chk("credit_still_low", 33'(can_issue), 33'(0));
    tick();
    @(negedge clk);
    chk("credit_recover", 33'(can_issue), 33'(1));
    drain();
    chk("no_ovf", 33'(ovf_err), 33'(0));

    // Stray root with nothing in the delay line
    tick();
    root_vld = 1'b1;
    root     = 24'hABCDEF;
    tick();
    @(negedge clk);
    chk("align_set",      33'(align_err), 33'(1));
    chk("align_no_write", 33'(res_vld),   33'(0));
    chk("align_credit",   33'(can_issue), 33'(1));

    // Forced issue beyond credit: its root is dropped
    fill(n_iss);
    tick();
    chk("force_no_credit", 33'(can_issue), 33'(0));
    do_issue({1'b0, 2'd0, 8'h90}, 24'hFFFFFF, '0, 1'b0);
    repeat (LAT + 3) tick();
    @(negedge clk);
    chk("ovf_set", 33'(ovf_err), 33'(1));
    drain();

    // Reset with 5 results queued and 3 roots still in the core
    res_rdy = 1'b0;
    tick();
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      rand_issue();
    end
    while (cyc < c0 + LAT + 5) tick();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_res_vld",   33'(res_vld),   33'(0));
    chk("mid_rst_res",       33'({res_inv, res}), 33'(0));
    chk("mid_rst_can_issue", 33'(can_issue), 33'(1));
    chk("mid_rst_ovf",       33'(ovf_err),   33'(0));
    chk("mid_rst_align",     33'(align_err), 33'(0));
    #1 rst = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("late_roots_align", 33'(align_err), 33'(1));
    chk("late_roots_empty", 33'(res_vld),   33'(0));

    // Clean reset before the random run
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Random traffic with random backpressure
    for (int k = 0; k < 600; k++) begin
      tick();
      res_rdy = ($urandom_range(0, 3) != 0);
      if (can_issue && $urandom_range(0, 2) != 0) rand_issue();
    end
    drain();
    chk("rand_ovf",   33'(ovf_err),   33'(0));
    chk("rand_align", 33'(align_err), 33'(0));
    chk("rand_sb_empty", 33'(sb.size()), 33'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
